// File: rtl/riscv_merger_if.sv
// rtl/riscv_merger_if.sv - AXI-Stream beat bundle shared by the merger inputs and output
interface riscv_merger_if #(
    parameter int DW = 512,
    parameter int UW = 128
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tlast;
    logic            tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/riscv_merger.sv
// rtl/riscv_merger.sv - packet-atomic round-robin 2:1 AXI-Stream merger (data path + RISC-V path)
// Optional RISCV_MERGER_PRIO_EN: RISC-V input gets strict priority at packet boundaries.
module riscv_merger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic           clk,
    input  logic           aresetn,
    riscv_merger_if.slave  s_data_axis,
    riscv_merger_if.slave  s_riscv_axis,
    riscv_merger_if.master m_axis
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = DW / 8;

    localparam logic GRANT_DATA  = 1'b0;
    localparam logic GRANT_RISCV = 1'b1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_DATA  = 2'd1,
        SEND_RISCV = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;

    logic [DW-1:0] out_data;
    logic [KW-1:0] out_keep;
    logic [UW-1:0] out_user;
    logic          out_valid;
    logic          out_last;

    logic load;
    logic acc_data;
    logic acc_riscv;
    logic accept;

    // Output register can take a new beat when empty or being drained this cycle
    assign load      = !out_valid || m_axis.tready;
    assign acc_data  = (state_q == SEND_DATA)  && load && s_data_axis.tvalid;
    assign acc_riscv = (state_q == SEND_RISCV) && load && s_riscv_axis.tvalid;
    assign accept    = acc_data || acc_riscv;

    assign s_data_axis.tready  = (state_q == SEND_DATA)  && load;
    assign s_riscv_axis.tready = (state_q == SEND_RISCV) && load;

    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tuser  = out_user;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_RISCV;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
`ifdef RISCV_MERGER_PRIO_EN
                if (s_riscv_axis.tvalid) begin
                    state_d      = SEND_RISCV;
                    last_grant_d = GRANT_RISCV;
                end else if (s_data_axis.tvalid) begin
                    state_d      = SEND_DATA;
                    last_grant_d = GRANT_DATA;
                end
`else
                if (s_data_axis.tvalid && s_riscv_axis.tvalid) begin
                    if (last_grant_q == GRANT_RISCV) begin
                        state_d      = SEND_DATA;
                        last_grant_d = GRANT_DATA;
                    end else begin
                        state_d      = SEND_RISCV;
                        last_grant_d = GRANT_RISCV;
                    end
                end else if (s_data_axis.tvalid) begin
                    state_d      = SEND_DATA;
                    last_grant_d = GRANT_DATA;
                end else if (s_riscv_axis.tvalid) begin
                    state_d      = SEND_RISCV;
                    last_grant_d = GRANT_RISCV;
                end
`endif
            end
            SEND_DATA: begin
                if (acc_data && s_data_axis.tlast) state_d = IDLE;
            end
            SEND_RISCV: begin
                if (acc_riscv && s_riscv_axis.tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload is only replaced on an accepted beat, so a stalled beat stays stable
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_user  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= accept;
            if (acc_riscv) begin
                out_data <= s_riscv_axis.tdata;
                out_keep <= s_riscv_axis.tkeep;
                out_user <= s_riscv_axis.tuser;
                out_last <= s_riscv_axis.tlast;
            end else if (acc_data) begin
                out_data <= s_data_axis.tdata;
                out_keep <= s_data_axis.tkeep;
                out_user <= s_data_axis.tuser;
                out_last <= s_data_axis.tlast;
            end
        end
    end
endmodule

// File: tb/tb_riscv_merger.sv
// tb/tb_riscv_merger.sv - directed self-checking bench for riscv_merger
module tb_riscv_merger;
    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam logic [KW-1:0] KALL = '1;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    riscv_merger_if #(.DW(DW), .UW(UW)) s_data_if ();
    riscv_merger_if #(.DW(DW), .UW(UW)) s_riscv_if ();
    riscv_merger_if #(.DW(DW), .UW(UW)) m_if ();

    riscv_merger #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_data_axis  (s_data_if),
        .s_riscv_axis (s_riscv_if),
        .m_axis       (m_if)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            c;
    } beat_t;

    beat_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur_idx[2] = '{-1, -1};
    int stab_err = 0;
    int stall_cnt = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic [UW-1:0] prev_u;
    logic [KW-1:0] prev_k;
    logic          prev_l;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_if.tvalid && m_if.tready)
            q.push_back('{d: m_if.tdata, k: m_if.tkeep, u: m_if.tuser, l: m_if.tlast, c: cyc});
        if (prev_stall && aresetn &&
            (!m_if.tvalid || m_if.tdata != prev_d || m_if.tuser != prev_u ||
             m_if.tkeep != prev_k || m_if.tlast != prev_l))
            stab_err <= stab_err + 1;
        if (aresetn && m_if.tvalid && !m_if.tready) stall_cnt <= stall_cnt + 1;
        prev_stall <= aresetn && m_if.tvalid && !m_if.tready;
        prev_d <= m_if.tdata;
        prev_u <= m_if.tuser;
        prev_k <= m_if.tkeep;
        prev_l <= m_if.tlast;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int tg, input int i);
        logic [DW-1:0] r;
        r = '0;
        r[63:0] = {tg, i};
        return r;
    endfunction

    task automatic drive(input int src, input logic v, input logic [DW-1:0] d,
                         input logic [KW-1:0] k, input logic [UW-1:0] u, input logic l);
        if (src == 0) begin
            s_data_if.tvalid = v; s_data_if.tdata = d; s_data_if.tkeep = k;
            s_data_if.tuser = u;  s_data_if.tlast = l;
        end else begin
            s_riscv_if.tvalid = v; s_riscv_if.tdata = d; s_riscv_if.tkeep = k;
            s_riscv_if.tuser = u;  s_riscv_if.tlast = l;
        end
    endtask

    // Presents one packet and waits for each handshake; aborts quietly on reset
    task automatic send_pkt(input int src, input int n, input int tg, input logic [KW-1:0] lastkeep,
                            output int first_hs, output int last_hs);
        logic hs;
        logic rdy;
        logic [KW-1:0] k;
        int to;
        first_hs = -1;
        last_hs = -1;
        for (int i = 0; i < n; i++) begin
            k = (i == n - 1) ? lastkeep : KALL;
            drive(src, 1'b1, mk_data(tg, i), k, UW'(tg), i == n - 1);
            cur_idx[src] = i;
            hs = 1'b0;
            to = 0;
            while (!hs && aresetn && to < 200) begin
                @(negedge clk);
                rdy = (src == 0) ? s_data_if.tready : s_riscv_if.tready;
                hs = rdy && aresetn;
                if (hs) begin
                    if (i == 0) first_hs = cyc;
                    last_hs = cyc;
                end
                @(posedge clk);
                #1;
                to++;
            end
            if (!hs) begin
                if (aresetn) check("hs_timeout", 0, 1);
                break;
            end
        end
        drive(src, 1'b0, '0, '0, '0, 1'b0);
        cur_idx[src] = -1;
    endtask

    task automatic expect_beat(input string tag, input int tg, input int i, input logic l,
                               input logic [KW-1:0] k, output int c);
        beat_t b;
        c = -1;
        if (q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
            return;
        end
        b = q.pop_front();
        c = b.c;
        check({tag, "_data"}, b.d, mk_data(tg, i));
        check({tag, "_user"}, b.u, tg);
        check({tag, "_last"}, b.l, l);
        check({tag, "_keep"}, b.k, k);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int start, c, c0, cl, fd, ld, fr, lr, to, s0, e0;
    int t2_tg[8]  = '{'h20, 'h20, 'h30, 'h30, 'h21, 'h21, 'h31, 'h31};
    int t2_off[8] = '{0, 1, 3, 4, 6, 7, 9, 10};
    int t4_off[4] = '{0, 3, 4, 5};

    initial begin
        drive(0, 1'b1, '0, '0, '0, 1'b0);
        drive(1, 1'b1, '0, '0, '0, 1'b0);
        m_if.tready = 1'b1;
        settle(3);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_tuser", m_if.tuser, 0);
        check("rst_tlast", m_if.tlast, 0);
        check("rst_tkeep", m_if.tkeep, 0);
        check("rst_data_tready", s_data_if.tready, 0);
        check("rst_riscv_tready", s_riscv_if.tready, 0);
        drive(0, 1'b0, '0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, '0, 1'b0);
        aresetn = 1'b1;
        settle(2);

        // 3-beat data packet, partial tkeep on the last beat
        q.delete();
        start = cyc;
        send_pkt(0, 3, 'h10, 64'h0000_0000_0000_FFFF, fd, ld);
        settle(3);
        check("t1_count", q.size(), 3);
        expect_beat("t1_b0", 'h10, 0, 1'b0, KALL, c0);
        check("t1_latency", c0, start + 2);
        expect_beat("t1_b1", 'h10, 1, 1'b0, KALL, c);
        check("t1_b1_cyc", c, c0 + 1);
        expect_beat("t1_b2", 'h10, 2, 1'b1, 64'h0000_0000_0000_FFFF, c);
        check("t1_b2_cyc", c, c0 + 2);

        // single-beat riscv packet
        q.delete();
        send_pkt(1, 1, 'hA5, KALL, fr, lr);
        settle(3);
        check("t5_count", q.size(), 1);
        expect_beat("t5_b0", 'hA5, 0, 1'b1, KALL, c);
        check("t5_idle_riscv_rdy", s_riscv_if.tready, 0);
        check("t5_idle_data_rdy", s_data_if.tready, 0);

        // both inputs continuously busy: strict alternation, 1-cycle gaps
        q.delete();
        fork
            begin
                send_pkt(0, 2, 'h20, KALL, fd, ld);
                send_pkt(0, 2, 'h21, KALL, fd, ld);
            end
            begin
                send_pkt(1, 2, 'h30, KALL, fr, lr);
                send_pkt(1, 2, 'h31, KALL, fr, lr);
            end
        join
        settle(3);
        check("t2_count", q.size(), 8);
        c0 = 0;
        for (int i = 0; i < 8; i++) begin
            expect_beat($sformatf("t2_b%0d", i), t2_tg[i], i % 2, (i % 2) == 1, KALL, c);
            if (i == 0) c0 = c;
            check($sformatf("t2_b%0d_off", i), c - c0, t2_off[i]);
        end

        // riscv rises on data beat 2: waits for the data tlast plus one IDLE cycle
        q.delete();
        fork
            send_pkt(0, 4, 'h40, KALL, fd, ld);
            begin
                to = 0;
                while (cur_idx[0] != 1 && to < 100) begin
                    @(negedge clk);
                    to++;
                end
                send_pkt(1, 2, 'h50, KALL, fr, lr);
            end
        join
        settle(3);
        check("t3_riscv_hs_gap", fr - ld, 2);
        check("t3_count", q.size(), 6);
        for (int i = 0; i < 4; i++) begin
            expect_beat($sformatf("t3_d%0d", i), 'h40, i, i == 3, KALL, c);
            if (i == 3) cl = c;
        end
        expect_beat("t3_r0", 'h50, 0, 1'b0, KALL, c);
        check("t3_out_gap", c - cl, 2);
        expect_beat("t3_r1", 'h50, 1, 1'b1, KALL, c);

        // downstream stall 1,0,0,1 during a 4-beat packet
        q.delete();
        s0 = stall_cnt;
        e0 = stab_err;
        fork
            send_pkt(1, 4, 'h60, KALL, fr, lr);
            begin
                to = 0;
                while (!m_if.tvalid && to < 100) begin
                    @(negedge clk);
                    to++;
                end
                @(posedge clk); #1; m_if.tready = 1'b0;
                @(posedge clk); #1; m_if.tready = 1'b0;
                @(posedge clk); #1; m_if.tready = 1'b1;
            end
        join
        settle(3);
        check("t4_stall_cycles", stall_cnt - s0, 2);
        check("t4_stable", stab_err - e0, 0);
        check("t4_count", q.size(), 4);
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            expect_beat($sformatf("t4_b%0d", i), 'h60, i, i == 3, KALL, c);
            if (i == 0) c0 = c;
            check($sformatf("t4_b%0d_off", i), c - c0, t4_off[i]);
        end

        // reset while beat 2 of 4 is on the output
        q.delete();
        fork
            send_pkt(0, 4, 'h70, KALL, fd, ld);
            begin
                to = 0;
                while (!(m_if.tvalid && m_if.tdata[31:0] == 32'd1 && m_if.tuser == UW'('h70)) && to < 100) begin
                    @(negedge clk);
                    to++;
                end
                if (to >= 100) check("t6_wait", 0, 1);
                aresetn = 1'b0;
                #1;
                check("t6_tvalid", m_if.tvalid, 0);
                check("t6_tdata", m_if.tdata, 0);
                check("t6_tuser", m_if.tuser, 0);
                check("t6_tlast", m_if.tlast, 0);
                check("t6_tkeep", m_if.tkeep, 0);
                check("t6_data_rdy", s_data_if.tready, 0);
                settle(2);
            end
        join
        q.delete();
        aresetn = 1'b1;
        settle(1);
        fork
            send_pkt(0, 2, 'h80, KALL, fd, ld);
            send_pkt(1, 1, 'h90, KALL, fr, lr);
        join
        settle(3);
        check("t6_count", q.size(), 3);
        expect_beat("t6_d0", 'h80, 0, 1'b0, KALL, c);
        expect_beat("t6_d1", 'h80, 1, 1'b1, KALL, c);
        expect_beat("t6_r0", 'h90, 0, 1'b1, KALL, c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
